// File: rtl/eth_output_comp_avlstrm_pkg.sv
// Shared types for the Ethernet output composer: metadata, packet-buffer flit and
// the output FIFO entry.
package eth_output_comp_avlstrm_pkg;

  localparam int unsigned PKT_AWIDTH    = 8;
  localparam int unsigned FLIT_IDX_W    = 6;
  localparam int unsigned PKTBUF_AWIDTH = PKT_AWIDTH + FLIT_IDX_W;
  localparam int unsigned ETH_DW        = 512;
  localparam int unsigned ETH_EW        = 6;

  typedef struct packed {
    logic [PKT_AWIDTH-1:0] pkt_id;
    logic [FLIT_IDX_W-1:0] flits;
  } metadata_t;

  localparam int unsigned META_WIDTH = $bits(metadata_t);

  typedef struct packed {
    logic [ETH_DW-1:0] data;
    logic [ETH_EW-1:0] empty;
  } flit_t;

  typedef struct packed {
    logic  sop;
    logic  eop;
    flit_t flit;
  } out_entry_t;

  // A zero flit count means a single-flit packet.
  function automatic logic [FLIT_IDX_W-1:0] last_flit_idx(input logic [FLIT_IDX_W-1:0] flits);
    return (flits == '0) ? '0 : flits - 1'b1;
  endfunction

endpackage

// File: rtl/eth_out_flit_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; pointers wrap
// modulo Depth, which must be a power of two.
module eth_out_flit_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (do_pop) rptr_d = rptr_q + 1'b1;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && (count_q == CntW'(Depth))))
    else $error("eth_out_flit_fifo: push while full");

endmodule

// File: rtl/eth_output_comp_avlstrm.sv
// Reads packet flits from the packet buffer under FIFO credit, streams them as
// Avalon-ST beats and returns the packet id to the empty list.
// Optional statistics counters: define ETH_OUTPUT_COMP_STATS_EN.
module eth_output_comp_avlstrm
  import eth_output_comp_avlstrm_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     in_meta_valid,
  output logic                     in_meta_ready,
  input  logic [META_WIDTH-1:0]    in_meta_data,
  output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_readaddress,
  output logic                     pkt_buffer_read,
  input  logic                     pkt_buffer_readvalid,
  input  flit_t                    pkt_buffer_readdata,
  output logic [511:0]             eth_data,
  output logic                     eth_sop,
  output logic                     eth_eop,
  output logic                     eth_valid,
  output logic [5:0]               eth_empty,
  input  logic                     eth_ready,
  output logic                     emptylist_valid,
  output logic [PKT_AWIDTH-1:0]    emptylist_data,
  input  logic                     emptylist_ready
`ifdef ETH_OUTPUT_COMP_STATS_EN
  ,
  output logic [31:0]              stats_out_pkt,
  output logic [31:0]              stats_out_flit
`endif
);

  typedef enum logic [1:0] {StIdle, StRead, StWaitLast, StRelease} state_e;

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SumW  = CntW + 1;
  localparam int unsigned DiscW = $clog2(READ_LATENCY + 1);

  state_e                state_q, state_d;
  logic [PKT_AWIDTH-1:0] pkt_id_q, pkt_id_d;
  logic [FLIT_IDX_W-1:0] last_idx_q, last_idx_d;
  logic [FLIT_IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [FLIT_IDX_W-1:0] push_idx_q, push_idx_d;
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic [DiscW-1:0]      discard_q, discard_d;

  metadata_t             meta;
  out_entry_t            push_entry;
  out_entry_t            head;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_empty;
  logic                  credit;
  logic                  rd_issue;
  logic                  rd_accept;
  logic                  meta_accept;
  logic                  pop;

  assign meta        = metadata_t'(in_meta_data);
  assign credit      = (SumW'(inflight_q) + SumW'(fifo_count)) < SumW'(FIFO_DEPTH);
  assign rd_issue    = (state_q == StRead) && credit && !Rst;
  // Returns with nothing outstanding (stale reads from before a reset) are dropped.
  assign rd_accept   = pkt_buffer_readvalid && (inflight_q != '0) && !Rst;
  assign meta_accept = in_meta_ready && in_meta_valid;
  assign pop         = eth_valid && eth_ready;

  always_comb begin
    push_entry.sop  = (push_idx_q == '0);
    push_entry.eop  = (push_idx_q == last_idx_q);
    push_entry.flit = pkt_buffer_readdata;
  end

  always_comb begin
    state_d    = state_q;
    pkt_id_d   = pkt_id_q;
    last_idx_d = last_idx_q;
    rd_idx_d   = rd_idx_q;
    push_idx_d = rd_accept ? push_idx_q + 1'b1 : push_idx_q;
    unique case (state_q)
      StIdle: begin
        if (meta_accept) begin
          pkt_id_d   = meta.pkt_id;
          last_idx_d = last_flit_idx(meta.flits);
          rd_idx_d   = '0;
          push_idx_d = '0;
          state_d    = StRead;
        end
      end
      StRead: begin
        if (rd_issue) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == last_idx_q) state_d = StWaitLast;
        end
      end
      StWaitLast: begin
        if (rd_accept && (push_idx_q == last_idx_q)) state_d = StRelease;
      end
      StRelease: begin
        if (emptylist_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (rd_issue && !rd_accept) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!rd_issue && rd_accept) begin
      inflight_d = inflight_q - 1'b1;
    end
    discard_d = (discard_q != '0) ? discard_q - 1'b1 : discard_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      pkt_id_q   <= '0;
      last_idx_q <= '0;
      rd_idx_q   <= '0;
      push_idx_q <= '0;
      inflight_q <= '0;
      discard_q  <= DiscW'(READ_LATENCY);
    end else begin
      state_q    <= state_d;
      pkt_id_q   <= pkt_id_d;
      last_idx_q <= last_idx_d;
      rd_idx_q   <= rd_idx_d;
      push_idx_q <= push_idx_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  eth_out_flit_fifo #(
    .Width ($bits(out_entry_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .push_i  (rd_accept),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    // Metadata is held off until reads issued before a reset can no longer return,
    // so a stale return is never counted against a new packet.
    in_meta_ready          = (state_q == StIdle) && (discard_q == '0) && !Rst;
    pkt_buffer_read        = rd_issue;
    pkt_buffer_readaddress = Rst ? '0 : {pkt_id_q, rd_idx_q};
    eth_valid              = !fifo_empty && !Rst;
    eth_data               = eth_valid ? head.flit.data : '0;
    eth_sop                = eth_valid && head.sop;
    eth_eop                = eth_valid && head.eop;
    eth_empty              = (eth_valid && head.eop) ? head.flit.empty : '0;
    emptylist_valid        = (state_q == StRelease) && !Rst;
    emptylist_data         = Rst ? '0 : pkt_id_q;
  end

`ifdef ETH_OUTPUT_COMP_STATS_EN
  logic [31:0] stats_pkt_q, stats_pkt_d;
  logic [31:0] stats_flit_q, stats_flit_d;

  always_comb begin
    stats_pkt_d  = stats_pkt_q + 32'(pop && eth_eop);
    stats_flit_d = stats_flit_q + 32'(pop);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stats_pkt_q  <= '0;
      stats_flit_q <= '0;
    end else begin
      stats_pkt_q  <= stats_pkt_d;
      stats_flit_q <= stats_flit_d;
    end
  end

  assign stats_out_pkt  = stats_pkt_q;
  assign stats_out_flit = stats_flit_q;
`endif

  assert property (@(posedge Clk) disable iff (Rst)
    !(pkt_buffer_readvalid && (inflight_q == '0) && (discard_q == '0)))
    else $error("eth_output_comp_avlstrm: readvalid with no read in flight");

endmodule

// File: doc/eth_output_comp_avlstrm.md
ETH_OUTPUT_COMP_AVLSTRM -- requirements
Module: eth_output_comp_avlstrm

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2: packet-buffer read latency, in cycles.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: output flit FIFO entries; must be a power of 2 and greater than READ_LATENCY+1.
REQ-003 SHALL have port Clk, in, 1: sole clock.
REQ-004 SHALL have port Rst, in, 1: synchronous, active-high reset.
REQ-005 SHALL have ports in_meta_valid/in_meta_ready, in/out, 1 each: metadata handshake.
REQ-006 SHALL have port in_meta_data, in, META_WIDTH: metadata_t; only the pktID and flits fields are used.
REQ-007 SHALL have ports pkt_buffer_readaddress, out, PKTBUF_AWIDTH, and pkt_buffer_read, out, 1.
REQ-008 SHALL have ports pkt_buffer_readvalid, in, 1, and pkt_buffer_readdata, in, flit_t.
REQ-009 SHALL have ports eth_data, out, 512; eth_sop, eth_eop, eth_valid, out, 1 each; eth_empty, out, 6; eth_ready, in, 1.
REQ-010 SHALL have ports emptylist_valid, out, 1; emptylist_data, out, PKT_AWIDTH; emptylist_ready, in, 1.

Function
REQ-011 SHALL implement a state machine with states IDLE, READ, WAIT_LAST and RELEASE.
REQ-012 IDLE SHALL assert in_meta_ready; when in_meta_valid is high it SHALL latch pktID and flits and go to READ.
REQ-013 A flits value of 0 SHALL be treated as 1.
REQ-014 READ SHALL issue one read per cycle while credit is available.
REQ-015 The read address SHALL be {pktID, flit_idx}, with flit_idx counting from 0 and 6 bits wide.
REQ-016 Credit SHALL mean (reads in flight + FIFO occupancy) < FIFO_DEPTH; when no credit is available, pkt_buffer_read SHALL be low.
REQ-017 After the read for flit_idx == flits-1 is issued, the FSM SHALL go to WAIT_LAST.
REQ-018 WAIT_LAST SHALL go to RELEASE on the cycle the final flit's readvalid is pushed into the FIFO.
REQ-019 RELEASE SHALL drive emptylist_valid=1 with emptylist_data=pktID, hold both until emptylist_ready is high, then go to IDLE.
REQ-020 Every readvalid flit SHALL be pushed into the FIFO.
REQ-021 eth_sop SHALL be 1 on flit_idx 0 only; eth_eop SHALL be 1 on the last flit only; eth_empty SHALL equal the buffered flit's empty field on eop and 0 otherwise.
REQ-022 eth_valid SHALL equal FIFO-not-empty; the FIFO SHALL pop only when eth_valid and eth_ready are both high.
REQ-023 eth outputs SHALL be held stable while eth_valid=1 and eth_ready=0.
REQ-024 The FIFO SHALL never overflow; this is guaranteed by credit.
REQ-025 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-026 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Latency SHALL be: meta accept -> first read 1 cycle; read -> FIFO push READ_LATENCY cycles; push -> eth_valid 1 cycle.
REQ-028 Sustained throughput SHALL be 1 flit/cycle within a packet when eth_ready=1.
REQ-029 Between packets there SHALL be a 2-cycle bubble, covering RELEASE and IDLE, plus drain.
REQ-030 A pkt_buffer_readvalid with no read in flight is illegal; it SHALL trigger an assertion in simulation and be ignored in logic.

Reset
REQ-031 On Rst, the FSM SHALL go to IDLE and counters, in-flight count and FIFO pointers SHALL clear.
REQ-032 While Rst is high, all valid, read, sop and eop outputs SHALL be 0; data, address and empty outputs SHALL be 0.
REQ-033 in_meta_ready SHALL be 0 while Rst is high.
REQ-034 A reset mid-packet SHALL drop the packet without releasing its pktID; an in-flight readvalid arriving after reset SHALL be discarded.

Configuration
REQ-035 The feature macro SHALL be ETH_OUTPUT_COMP_STATS_EN.
REQ-036 With ETH_OUTPUT_COMP_STATS_EN defined, the block SHALL add outputs stats_out_pkt and stats_out_flit, 32 bits each.
REQ-037 stats_out_pkt SHALL increment on each accepted eop beat; stats_out_flit SHALL increment on each accepted beat; both SHALL wrap at 2^32 and clear on Rst.
REQ-038 Without ETH_OUTPUT_COMP_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-039 metadata_t, flit_t, META_WIDTH, PKT_AWIDTH and PKTBUF_AWIDTH SHALL come from the shared struct package.
REQ-040 The FSM state enum SHALL be declared locally in this module.
REQ-041 The output FIFO SHALL be the sub-module eth_out_flit_fifo, a synchronous FWFT FIFO with a count output.

Verification
REQ-042 Meta pktID=5, flits=1, empty=10, eth_ready=1 -> reads address {5,0}; one beat with sop=1, eop=1, empty=10; emptylist returns 5.
REQ-043 Meta flits=4, eth_ready=1 -> 4 consecutive reads, then 4 back-to-back beats with sop on beat 0 and eop on beat 3; one release.
REQ-044 Meta flits=20, eth_ready=0 for 30 cycles -> at most 8 reads issued; no FIFO overflow; all 20 beats delivered in order after ready rises.
REQ-045 emptylist_ready=0 for 10 cycles -> emptylist_valid held with pktID stable; in_meta_ready stays 0 until release.
REQ-046 flits=0 -> behaves exactly as flits=1.
REQ-047 Rst pulsed mid-packet at beat 2 of 6 -> all outputs 0 during reset; next meta (pktID=9, flits=2) is emitted cleanly with no stale beats.
